// File: rtl/sal_axi_mem_responder_if.sv
// AXI4 channel bundle between a bench initiator (master) and the SRAM-backed
// responder (slave). Clock and reset are carried separately as plain ports.
interface sal_axi_mem_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    localparam int NB = DATA_WIDTH / 8;

    // Write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    // Write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    // Write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    // Read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    // Read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/sal_axi_mem_responder.sv
// AXI4 responder backed by a word-addressed 1W+1R SRAM. Independent read and
// write engines, each holding at most one transaction. Out-of-range beats and
// malformed requests are answered with SLVERR; the SRAM itself is never reset.
module sal_axi_mem_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int MEM_DEPTH  = 256
) (
    input logic                    clk,
    input logic                    rst_n,
    sal_axi_mem_responder_if.slave axi
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    localparam logic [2:0]            SIZE_OK     = 3'(OFF_W);
    localparam logic [1:0]            BURST_FIXED = 2'b00;
    localparam logic [1:0]            BURST_INCR  = 2'b01;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(MEM_DEPTH);

    // A request whose size is not the full bus width or whose burst is WRAP /
    // reserved never touches the SRAM and answers SLVERR on every beat.
    function automatic logic fmt_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_OK) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    // Word index is kept at full address width so INCR never wraps back into range.
    function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr >> OFF_W;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] idx,
                                                       input logic [1:0]            burst);
        return (burst == BURST_INCR) ? idx + ADDR_WIDTH'(1) : idx;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_len;
    logic [3:0]            w_cnt;
    logic [1:0]            w_burst;
    logic                  w_bad;
    logic                  w_err;
    logic                  aw_hs, w_beat, w_last;
    logic                  w_in_range, w_beat_err, w_commit;

    assign w_in_range = (w_idx < DEPTH_A);
    assign w_beat_err = !w_in_range || (axi.wlast != w_last);
    assign w_commit   = w_beat && w_in_range && !w_bad;

    // Next write state and the handshake strobes it depends on
    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        w_beat = 1'b0;
        w_last = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_hs = axi.awvalid && axi.awready;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                w_beat = axi.wvalid && axi.wready;
                w_last = (w_cnt == w_len);
                if (w_beat && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                if (axi.bvalid && axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write state, registered handshake outputs, beat counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= RESP_OKAY;
            w_cnt       <= '0;
            w_bad       <= 1'b0;
            w_err       <= 1'b0;
        end else begin
            w_state     <= w_next;
            axi.awready <= (w_next == W_IDLE);
            axi.wready  <= (w_next == W_DATA);
            axi.bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_cnt <= '0;
                w_bad <= fmt_bad(axi.awsize, axi.awburst);
                w_err <= fmt_bad(axi.awsize, axi.awburst);
            end
            if (w_beat) begin
                w_cnt <= w_cnt + 4'd1;
                if (w_beat_err) w_err <= 1'b1;
                if (w_last) begin
                    axi.bid   <= w_id;
                    axi.bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Write request fields, captured at AW and advanced per beat
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_id    <= axi.awid;
            w_idx   <= word_idx(axi.awaddr);
            w_len   <= axi.awlen;
            w_burst <= axi.awburst;
        end else if (w_beat) begin
            w_idx   <= next_idx(w_idx, w_burst);
        end
    end

    // SRAM write port: byte lanes with wstrb set are updated, others kept
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < NB; k++) begin
                if (axi.wstrb[k]) mem[w_idx[MEM_AW-1:0]][8*k +: 8] <= axi.wdata[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_len;
    logic [3:0]            r_cnt;
    logic [1:0]            r_burst;
    logic                  r_bad;
    logic                  ar_hs, r_load;
    logic [ADDR_WIDTH-1:0] ld_idx;
    logic                  ld_bad, ld_last, ld_ok;

    assign ld_ok = !ld_bad && (ld_idx < DEPTH_A);

    // Next read state and the beat to load (first beat at AR, then on each accept)
    always_comb begin
        r_next  = r_state;
        ar_hs   = 1'b0;
        r_load  = 1'b0;
        ld_idx  = r_idx;
        ld_bad  = r_bad;
        ld_last = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_hs   = axi.arvalid && axi.arready;
                ld_idx  = word_idx(axi.araddr);
                ld_bad  = fmt_bad(axi.arsize, axi.arburst);
                ld_last = (axi.arlen == 4'd0);
                if (ar_hs) begin
                    r_load = 1'b1;
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rvalid && axi.rready) begin
                    if (axi.rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        r_load  = 1'b1;
                        ld_idx  = next_idx(r_idx, r_burst);
                        ld_last = ((r_cnt + 4'd1) == r_len);
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read state, registered R channel (held while stalled) and SRAM read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rresp   <= RESP_OKAY;
            axi.rid     <= '0;
            axi.rdata   <= '0;
            r_cnt       <= '0;
            r_bad       <= 1'b0;
        end else begin
            r_state     <= r_next;
            axi.arready <= (r_next == R_IDLE);
            axi.rvalid  <= (r_next == R_DATA);
            if (r_load) begin
                axi.rlast <= ld_last;
                axi.rresp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                axi.rdata <= ld_ok ? mem[ld_idx[MEM_AW-1:0]] : '0;
                axi.rid   <= ar_hs ? axi.arid : r_id;
            end
            if (ar_hs) begin
                r_cnt <= '0;
                r_bad <= ld_bad;
            end else if (r_load) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Read request fields, captured at AR; index tracks the beat on the bus
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_id    <= axi.arid;
            r_len   <= axi.arlen;
            r_burst <= axi.arburst;
        end
        if (r_load) r_idx <= ld_idx;
    end
endmodule

// File: tb/tb_sal_axi_mem_responder.sv
// Randomized scoreboard bench for sal_axi_mem_responder. A transaction-level
// memory model predicts B and R responses when stimulus is issued; a monitor
// pops and compares them as the DUT presents each response.
module tb_sal_axi_mem_responder;
    localparam int IDW = 4, AW = 32, DW = 128, DEPTH = 256;

    logic clk, rst_n;

    sal_axi_mem_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    sal_axi_mem_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [127:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t         exp_b[$];
    r_exp_t         exp_r[$];
    b_exp_t         eb;
    r_exp_t         er;
    logic [127:0]   mdl [DEPTH];
    logic [127:0]   wd [16];
    logic [15:0]    ws [16];
    logic           wl [16];
    int             n_checks = 0;
    int             n_pass = 0;
    bit             rpat = 1'b0;
    int             rpat_cnt = 0;
    int             r_beats = 0;
    bit             b_hold = 1'b0, r_hold = 1'b0;
    logic [5:0]     b_saved;
    logic [134:0]   r_saved;
    logic [127:0]   last_rdata;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [2:0] size, input logic [1:0] burst);
        bit bad = (size != 3'd4) || (burst[1] == 1'b1);
        bit err = bad;
        int unsigned idx = addr >> 4;
        for (int b = 0; b <= len; b++) begin
            if (wl[b] != (b == len)) err = 1'b1;
            if (idx >= DEPTH) err = 1'b1;
            else if (!bad) begin
                for (int k = 0; k < 16; k++)
                    if (ws[b][k]) mdl[idx][8*k +: 8] = wd[b][8*k +: 8];
            end
            if (burst == 2'b01) idx++;
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                                       input logic [2:0] size, input logic [1:0] burst);
        bit bad = (size != 3'd4) || (burst[1] == 1'b1);
        int unsigned idx = addr >> 4;
        r_exp_t e;
        for (int b = 0; b <= len; b++) begin
            bit ok = !bad && (idx < DEPTH);
            e.id   = id;
            e.data = ok ? mdl[idx] : 128'h0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.last = (b == len);
            exp_r.push_back(e);
            if (burst == 2'b01) idx++;
        end
    endfunction

    // ---------------- channel drivers ----------------
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output time t);
        bit done = 1'b0;
        t = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (axi.awready) begin t = $time; done = 1'b1; end
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        chk("aw_accept", done, 1);
    endtask

    task automatic do_w(input int b);
        bit done = 1'b0;
        axi.wdata = wd[b]; axi.wstrb = ws[b]; axi.wlast = wl[b];
        axi.wvalid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (axi.wready) done = 1'b1;
        end
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        chk("w_accept", done, 1);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output time t);
        bit done = 1'b0;
        t = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (axi.arready) begin t = $time; done = 1'b1; end
        end
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        chk("ar_accept", done, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && i < 2000) begin
            @(posedge clk); #1;
            i++;
        end
        chk("drain", exp_b.size() + exp_r.size(), 0);
        exp_b.delete();
        exp_r.delete();
    endtask

    task automatic fill_beats(input int len, input bit strb_rand, input bit bad_last);
        int k;
        for (int b = 0; b <= len; b++) begin
            wd[b] = {$urandom, $urandom, $urandom, $urandom};
            ws[b] = strb_rand ? 16'($urandom) : 16'hFFFF;
            wl[b] = (b == len);
        end
        if (bad_last) begin
            k = $urandom_range(0, len);
            wl[k] = !wl[k];
        end
    endtask

    task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        time t;
        eb.id = id;
        eb.resp = model_write(addr, int'(len), size, burst);
        exp_b.push_back(eb);
        do_aw(id, addr, len, size, burst, t);
        for (int b = 0; b <= int'(len); b++) do_w(b);
        wait_idle();
    endtask

    task automatic run_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        time t;
        model_read(id, addr, int'(len), size, burst);
        do_ar(id, addr, len, size, burst, t);
        wait_idle();
    endtask

    // ---------------- response-side ready generation ----------------
    always @(posedge clk) begin
        #1;
        axi.bready = ($urandom_range(0, 3) != 0);
        if (rpat) begin
            axi.rready = ((rpat_cnt % 4) == 0) || ((rpat_cnt % 4) == 3);
            rpat_cnt++;
        end else begin
            axi.rready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            b_hold = 1'b0;
            r_hold = 1'b0;
        end else begin
            if (axi.bvalid) begin
                if (b_hold) chk("b_stable", {axi.bid, axi.bresp}, b_saved);
                if (axi.bready) begin
                    if (exp_b.size() == 0) chk("b_unexpected", axi.bvalid, 0);
                    else begin
                        eb = exp_b.pop_front();
                        chk("b_resp", {axi.bid, axi.bresp}, {eb.id, eb.resp});
                    end
                    b_hold = 1'b0;
                end else begin
                    b_saved = {axi.bid, axi.bresp};
                    b_hold  = 1'b1;
                end
            end else begin
                b_hold = 1'b0;
            end
            if (axi.rvalid) begin
                if (r_hold) chk("r_stable", {axi.rid, axi.rresp, axi.rlast, axi.rdata}, r_saved);
                if (axi.rready) begin
                    r_beats++;
                    last_rdata = axi.rdata;
                    if (exp_r.size() == 0) chk("r_unexpected", axi.rvalid, 0);
                    else begin
                        er = exp_r.pop_front();
                        chk("r_beat", {axi.rid, axi.rresp, axi.rlast, axi.rdata},
                            {er.id, er.resp, er.last, er.data});
                    end
                    r_hold = 1'b0;
                end else begin
                    r_saved = {axi.rid, axi.rresp, axi.rlast, axi.rdata};
                    r_hold  = 1'b1;
                end
            end else begin
                r_hold = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        time         t0, t_aw, t_ar;
        int          b4;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;

        rst_n = 1'b0;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}, 0);
        chk("rst_data", {axi.bid, axi.bresp, axi.rid, axi.rresp, axi.rdata}, 0);
        rst_n = 1'b1;
        #1 chk("awready_before_edge", axi.awready, 0);
        @(negedge clk);
        chk("ready_after_release", {axi.awready, axi.arready}, 2'b11);
        @(posedge clk); #1;

        // Give every SRAM word a known value
        for (int w = 0; w < 16; w++) begin
            fill_beats(15, 1'b0, 1'b0);
            run_write(4'(w), 32'(w * 256), 4'd15, 3'd4, 2'b01);
        end

        // 1: two-beat INCR write and readback
        fill_beats(1, 1'b0, 1'b0);
        wd[0] = {4{32'h01234567}};
        wd[1] = {4{32'h01234567}};
        run_write(4'd0, 32'h0, 4'd1, 3'd4, 2'b01);
        run_read(4'd0, 32'h0, 4'd1, 3'd4, 2'b01);

        // 2: partial byte-lane write
        fill_beats(0, 1'b0, 1'b0);
        wd[0] = '1;
        run_write(4'd1, 32'h0, 4'd0, 3'd4, 2'b01);
        fill_beats(0, 1'b0, 1'b0);
        wd[0] = '0;
        ws[0] = 16'h00FF;
        run_write(4'd1, 32'h0, 4'd0, 3'd4, 2'b01);
        run_read(4'd2, 32'h0, 4'd0, 3'd4, 2'b01);
        chk("strobe_readback", last_rdata, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // 3: burst running off the top of memory
        fill_beats(1, 1'b0, 1'b0);
        run_write(4'd3, 32'((DEPTH - 1) * 16), 4'd1, 3'd4, 2'b01);
        run_read(4'd3, 32'((DEPTH - 1) * 16), 4'd1, 3'd4, 2'b01);

        // Error and FIXED-burst cases
        fill_beats(1, 1'b1, 1'b0);
        run_write(4'd4, 32'(10 * 16), 4'd1, 3'd3, 2'b01);
        fill_beats(2, 1'b0, 1'b0);
        run_write(4'd5, 32'(20 * 16), 4'd2, 3'd4, 2'b10);
        fill_beats(2, 1'b0, 1'b0);
        run_write(4'd5, 32'(24 * 16), 4'd2, 3'd4, 2'b11);
        fill_beats(2, 1'b0, 1'b1);
        run_write(4'd6, 32'(28 * 16), 4'd2, 3'd4, 2'b01);
        fill_beats(3, 1'b1, 1'b0);
        run_write(4'd7, 32'(32 * 16), 4'd3, 3'd4, 2'b00);
        run_read(4'd4, 32'(10 * 16), 4'd1, 3'd4, 2'b01);
        run_read(4'd5, 32'(20 * 16), 4'd3, 3'd4, 2'b10);
        run_read(4'd5, 32'(20 * 16), 4'd3, 3'd2, 2'b01);
        run_read(4'd6, 32'(28 * 16), 4'd2, 3'd4, 2'b01);
        run_read(4'd7, 32'(32 * 16), 4'd3, 3'd4, 2'b00);
        run_read(4'd7, 32'(32 * 16), 4'd0, 3'd4, 2'b01);

        // 4: stalled 4-beat read
        rpat = 1'b1;
        b4 = r_beats;
        run_read(4'd8, 32'(40 * 16), 4'd3, 3'd4, 2'b01);
        chk("stall_beats", r_beats - b4, 4);
        rpat = 1'b0;

        // 5: AW and AR to the same word in the same cycle
        fill_beats(0, 1'b0, 1'b0);
        model_read(4'd9, 32'(50 * 16), 0, 3'd4, 2'b01);
        eb.id = 4'd10;
        eb.resp = model_write(32'(50 * 16), 0, 3'd4, 2'b01);
        exp_b.push_back(eb);
        t0 = $time;
        fork
            begin
                do_aw(4'd10, 32'(50 * 16), 4'd0, 3'd4, 2'b01, t_aw);
                do_w(0);
            end
            do_ar(4'd9, 32'(50 * 16), 4'd0, 3'd4, 2'b01, t_ar);
        join
        chk("aw_same_cycle", t_aw, t0 + 4);
        chk("ar_same_cycle", t_ar, t0 + 4);
        wait_idle();
        run_read(4'd11, 32'(50 * 16), 4'd0, 3'd4, 2'b01);

        // 6: reset during beat 1 of a 4-beat write
        fill_beats(3, 1'b0, 1'b0);
        mdl[60] = wd[0];
        do_aw(4'd12, 32'(60 * 16), 4'd3, 3'd4, 2'b01, t_aw);
        do_w(0);
        axi.wdata = wd[1]; axi.wstrb = ws[1]; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1 axi.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midburst_rst_ctrl", {axi.awready, axi.wready, axi.bvalid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_release", axi.awready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_bvalid_after_abort", axi.bvalid, 0);
        end
        @(posedge clk); #1;
        run_read(4'd13, 32'(60 * 16), 4'd3, 3'd4, 2'b01);
        fill_beats(1, 1'b1, 1'b0);
        run_write(4'd14, 32'(60 * 16), 4'd1, 3'd4, 2'b01);
        run_read(4'd14, 32'(60 * 16), 4'd1, 3'd4, 2'b01);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            len   = 4'($urandom_range(0, 15));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(250, 265) * 16)
                                                : 32'($urandom_range(0, DEPTH - 1) * 16);
            if ($urandom_range(0, 1) == 1) begin
                fill_beats(int'(len), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
                run_write(4'($urandom), addr, len, size, burst);
            end else begin
                run_read(4'($urandom), addr, len, size, burst);
            end
        end

        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
